fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Sequences the program counter and instruction fetch for the base RISC-V core. Owns the PC register, issues single-outstanding requests to instruction memory and presents fetched instructions to decode with a valid/stall handshake. Applies next-PC selection with priority trap > redirect > sequential (+4), and discards responses to stale fetches.

Parameters:
RESET_VECTOR, 32'h00000000, PC value loaded on reset
TRAP_VECTOR, 32'h00000100, PC value loaded on trap or misaligned redirect

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  decode cannot accept the presented instruction this cycle
redirect_valid  input  1  taken branch/jump this cycle
redirect_pc  input  32  branch/jump target
trap  input  1  exception/trap request this cycle
imem_req  output  1  fetch request strobe, one cycle per request
imem_addr  output  32  fetch address, valid while imem_req=1
imem_ready  input  1  response strobe; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
inst_valid  output  1  inst_out/inst_pc hold a live instruction
inst_out  output  32  instruction to decode
inst_pc  output  32  address of inst_out
pc_out  output  32  current fetch PC
fault  output  1  one-cycle pulse: redirect target misaligned

Behaviour:
- Reset (sync, active-high, any state): pc_out=RESET_VECTOR, state=IDLE, imem_req=0, imem_addr=0, inst_valid=0, inst_out=32'h00000013 (NOP), inst_pc=0, fault=0, kill=0.
- States: IDLE, REQ, WAIT, HOLD. All outputs are registered except imem_req/imem_addr, which decode the state (imem_req=1 iff state==REQ; imem_addr=pc_out).
- IDLE: lasts one cycle after reset -> REQ.
- REQ: request accepted unconditionally in this cycle -> WAIT. Memory response arrives >=1 cycle later.
- WAIT: stays until imem_ready=1. On imem_ready with kill=0: inst_out<=imem_rdata, inst_pc<=pc_out, inst_valid<=1, pc_out<=pc_out+4 (mod 2^32, wraps FFFFFFFC->00000000), -> HOLD. On imem_ready with kill=1: response dropped, kill<=0, -> REQ.
- HOLD: inst_valid=1 and inst_out/inst_pc held while stall=1. When stall=0, the instruction is consumed that cycle: next cycle inst_valid=0, -> REQ.
- Next-PC priority, evaluated every cycle outside reset: trap > redirect_valid > sequential.
  - trap: pc_out<=TRAP_VECTOR.
  - redirect_valid, redirect_pc[1:0]==0: pc_out<=redirect_pc.
  - redirect_valid, redirect_pc[1:0]!=0: treated as trap; pc_out<=TRAP_VECTOR, fault pulses 1 the next cycle.
- Redirect/trap effects by state:
  - IDLE: PC update only, -> REQ.
  - REQ: the request in flight is stale; kill<=1, -> WAIT.
  - WAIT, no imem_ready: kill<=1, stay WAIT.
  - WAIT, imem_ready same cycle: response discarded, kill<=0, -> REQ.
  - HOLD: flush, inst_valid<=0 next cycle regardless of stall, -> REQ.
- The redirect PC overrides the +4 increment of any same-cycle capture.
- imem_ready outside WAIT is ignored (no state or output change).
- Only one request is outstanding at a time; imem_req never asserts in WAIT or HOLD.
- Steady state with no stalls and 1-cycle memory: one instruction per 3 cycles (REQ, WAIT, HOLD).

Test Plan:
- Reset then free-run, 1-cycle memory, stall=0 -> imem_addr sequence 0,4,8,C; inst_pc matches; inst_valid pulses once per 3 cycles; reset outputs NOP/0.
- Stall=1 for 4 cycles in HOLD at pc 0x8 -> inst_out/inst_pc(0x8) stable, inst_valid=1, no imem_req; after release, next fetch at 0xC.
- redirect_valid with redirect_pc=0x40 in WAIT, response 2 cycles later -> response dropped, inst_valid stays 0, next imem_addr=0x40.
- trap and redirect_valid(0x80) in same cycle -> pc_out=0x100, fault=0; redirect_pc=0x42 alone -> pc_out=0x100, fault one-cycle pulse.
- Redirect in HOLD with stall=1 -> inst_valid=0 next cycle, fetch at the target.
- PC at 0xFFFFFFFC captured -> pc_out wraps to 0x00000000.
- Reset asserted mid-WAIT, late imem_ready the next cycle -> ignored, first request at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Program counter and single-outstanding instruction fetch sequencer.
// Next PC priority: trap > redirect > sequential; stale responses are dropped via kill.
//
// state | meaning
// IDLE  | one cycle after reset, no request
// REQ   | imem_req asserted for pc_out
// WAIT  | awaiting imem_ready for the outstanding request
// HOLD  | instruction presented to decode until consumed or flushed
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h00000100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [31:0] pc_out,
    output logic        fault
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] ipc_q, ipc_d;
    logic        kill_q, kill_d;
    logic        fault_q, fault_d;

    logic        flush;
    logic        misaligned;
    logic [31:0] target;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
            inst_q  <= NOP;
            ipc_q   <= 32'h00000000;
            kill_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
            kill_q  <= kill_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        inst_d     = inst_q;
        ipc_d      = ipc_q;
        kill_d     = kill_q;
        flush      = trap | redirect_valid;
        misaligned = (redirect_pc[1:0] != 2'b00);
        target     = (trap || misaligned) ? TRAP_VECTOR : redirect_pc;
        // A trap outranks the redirect, so its misalignment is not reported.
        fault_d    = redirect_valid & ~trap & misaligned;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                state_d = WAIT;
                if (flush) kill_d = 1'b1;
            end
            WAIT: begin
                if (imem_ready) begin
                    if (flush || kill_q) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d  = imem_rdata;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        state_d = HOLD;
                    end
                end else if (flush) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (flush || !stall) begin
                    valid_d = 1'b0;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) pc_d = target;
    end

    assign imem_req   = (state_q == REQ);
    assign imem_addr  = pc_q;
    assign inst_valid = valid_q;
    assign inst_out   = inst_q;
    assign inst_pc    = ipc_q;
    assign pc_out     = pc_q;
    assign fault      = fault_q;

endmodule
